// File: rtl/rs_enc_lfsr_pkg.sv
// GF(2^8) arithmetic, RS generator polynomial and encoder state type shared by
// the systematic Reed-Solomon encoder.
package rs_enc_lfsr_pkg;

  localparam int SYMB_WIDTH = 8;
  localparam int T_LEN      = 8;
  localparam int PAR_LEN    = 2 * T_LEN;
  localparam logic [SYMB_WIDTH:0] PRIM_POLY = 9'h11D;

  typedef logic [SYMB_WIDTH-1:0] symb_t;
  typedef logic [PAR_LEN-1:0][SYMB_WIDTH-1:0] gen_poly_t;
  typedef enum logic {MSG, PARITY} enc_state_e;

  function automatic symb_t gf_mult(input symb_t a, input symb_t b);
    symb_t acc;
    symb_t sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < SYMB_WIDTH; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = sh[SYMB_WIDTH-1] ? ((sh << 1) ^ PRIM_POLY[SYMB_WIDTH-1:0]) : (sh << 1);
    end
    return acc;
  endfunction

  // g(x) = prod_{i=1..PAR_LEN} (x + alpha^i); the monic x^PAR_LEN term is dropped.
  function automatic gen_poly_t gen_poly_calc();
    logic [PAR_LEN:0][SYMB_WIDTH-1:0] g;
    symb_t root;
    g    = '0;
    g[0] = symb_t'(1);
    root = symb_t'(1);
    for (int i = 1; i <= PAR_LEN; i++) begin
      root = gf_mult(root, symb_t'(2));
      for (int k = PAR_LEN; k >= 1; k--) g[k] = g[k-1] ^ gf_mult(g[k], root);
      g[0] = gf_mult(g[0], root);
    end
    return g[PAR_LEN-1:0];
  endfunction

  localparam gen_poly_t GEN_POLY = gen_poly_calc();

endpackage

// File: rtl/rs_enc_lfsr_core.sv
// Parity remainder register bank: GF feedback division on load, plain
// upward shift with zero fill on shift (parity readout).
module rs_enc_lfsr_core
  import rs_enc_lfsr_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  shift,
  input  logic [SYMB_WIDTH-1:0] din,
  output logic [SYMB_WIDTH-1:0] rem_top
);

  logic [PAR_LEN-1:0][SYMB_WIDTH-1:0] rem;
  symb_t fb;

  assign fb      = din ^ rem[PAR_LEN-1];
  assign rem_top = rem[PAR_LEN-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem <= '0;
    end else if (load) begin
      rem[0] <= gf_mult(fb, GEN_POLY[0]);
      for (int j = 1; j < PAR_LEN; j++) rem[j] <= rem[j-1] ^ gf_mult(fb, GEN_POLY[j]);
    end else if (shift) begin
      rem[0] <= '0;
      for (int j = 1; j < PAR_LEN; j++) rem[j] <= rem[j-1];
    end
  end

endmodule

// File: rtl/rs_enc_lfsr.sv
// Systematic RS encoder: forwards message symbols, then appends PAR_LEN parity
// symbols through a single-register AXI-stream output slice.
module rs_enc_lfsr
  import rs_enc_lfsr_pkg::*;
#(
  parameter int K_LEN = 239
)
(
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic [SYMB_WIDTH-1:0] s_tdata,
  input  logic                  s_tlast,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic [SYMB_WIDTH-1:0] m_tdata,
  output logic                  m_tlast,
  output logic                  len_err_o
);

  localparam int MCNT_W = $clog2(K_LEN + 1);
  localparam int PCNT_W = $clog2(PAR_LEN);

  enc_state_e        state, state_nxt;
  logic [MCNT_W-1:0] msg_cnt;
  logic [PCNT_W-1:0] par_cnt;
  logic              adv, accept, par_load, cnt_full, par_last;
  symb_t             rem_top;

  assign adv      = !m_tvalid || m_tready;
  // Gated by aresetn so the source never sees ready while reset is held.
  assign s_tready = (state == MSG) && adv && aresetn;
  assign accept   = s_tvalid && s_tready;
  assign par_load = (state == PARITY) && adv;
  assign cnt_full = (msg_cnt == MCNT_W'(K_LEN - 1));
  assign par_last = (par_cnt == PCNT_W'(PAR_LEN - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      MSG:     if (accept && (s_tlast || cnt_full)) state_nxt = PARITY;
      PARITY:  if (par_load && par_last) state_nxt = MSG;
      default: state_nxt = MSG;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= MSG;
      msg_cnt   <= '0;
      par_cnt   <= '0;
      len_err_o <= 1'b0;
    end else begin
      state     <= state_nxt;
      len_err_o <= accept && cnt_full && !s_tlast;
      if (par_load && par_last) msg_cnt <= '0;
      else if (accept)          msg_cnt <= msg_cnt + MCNT_W'(1);
      if (par_load) par_cnt <= par_last ? '0 : par_cnt + PCNT_W'(1);
    end
  end

  // Output register slice: message pass-through or parity readout.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      m_tlast  <= 1'b0;
    end else if (accept) begin
      m_tvalid <= 1'b1;
      m_tdata  <= s_tdata;
      m_tlast  <= 1'b0;
    end else if (par_load) begin
      m_tvalid <= 1'b1;
      m_tdata  <= rem_top;
      m_tlast  <= par_last;
    end else if (adv) begin
      m_tvalid <= 1'b0;
    end
  end

  rs_enc_lfsr_core u_core (
    .clk     (aclk),
    .rst_n   (aresetn),
    .load    (accept),
    .shift   (par_load),
    .din     (s_tdata),
    .rem_top (rem_top)
  );

endmodule

// File: doc/rs_enc_lfsr.md
Name: rs_enc_lfsr

Overview:
- Systematic Reed-Solomon encoder over GF(2^SYMB_WIDTH); the transmit-side counterpart of the decoder's syndrome/Chien polynomial-evaluation path.
- Accepts a message stream, forwards message symbols unchanged, then appends 2*T_LEN parity symbols.
- Parity is the remainder of m(x)*x^(2T) divided by the generator polynomial, computed with a feedback LFSR built from gf_mult.
- Sits at the transmit egress, ahead of the channel model or serializer.

Parameters:
- K_LEN, 239, maximum message symbols per codeword; shortened codes accepted.
- PAR_LEN, 2*T_LEN, parity symbols per codeword. Fixed by gf_pkg; not overridable.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset; asynchronous, active-low.
- s_tvalid  in  1  input symbol valid.
- s_tready  out  1  encoder accepts input symbol.
- s_tdata  in  SYMB_WIDTH  message symbol, highest-degree first.
- s_tlast  in  1  last message symbol of the frame.
- m_tvalid  out  1  output symbol valid.
- m_tready  in  1  downstream accepts output.
- m_tdata  out  SYMB_WIDTH  message or parity symbol.
- m_tlast  out  1  last parity symbol.
- len_err_o  out  1  one-cycle pulse: K_LEN symbols received without s_tlast.

Behaviour:
- Reset: m_tvalid=0, m_tdata=0, m_tlast=0, len_err_o=0, s_tready=0 during reset. LFSR registers rem[PAR_LEN-1:0]=0, counters=0, state=MSG.
- Output stage is a single register slice. It loads when !m_tvalid || m_tready ("adv").
- State MSG:
  - s_tready = adv.
  - On accept: m_tdata<=s_tdata, m_tlast<=0, m_tvalid<=1.
  - fb = s_tdata ^ rem[PAR_LEN-1].
  - rem[j] <= rem[j-1] ^ gf_mult(fb, GEN_POLY[j]) for j>0; rem[0] <= gf_mult(fb, GEN_POLY[0]).
  - msg_cnt increments.
  - Leave MSG for PARITY when s_tlast is accepted, or when msg_cnt reaches K_LEN-1 on accept. In the count case, len_err_o pulses 1 cycle and the frame is terminated there.
- State PARITY:
  - s_tready=0.
  - On adv: m_tdata<=rem[PAR_LEN-1], shift rem up by one with zero fill, m_tvalid<=1.
  - par_cnt increments; m_tlast<=1 when par_cnt==PAR_LEN-1.
  - After the last parity is loaded: state<=MSG, msg_cnt=par_cnt=0, rem is all zero by construction.
- In either state, adv with no load drops m_tvalid to 0.
- Latency: 1 cycle input-accept to m_tvalid. Throughput is 1 symbol/cycle with m_tready high. Codeword occupies L+PAR_LEN output beats, with no bubbles when m_tvalid and m_tready are held high.
- Shortened codes: L < K_LEN is legal. Implicit leading zeros do not alter the remainder.
- Length-1 frame (s_tlast on the first symbol) is legal.
- m_tready low holds m_tdata/m_tlast stable and stalls both the LFSR and the counters. The LFSR only updates on accept.
- s_tvalid is ignored in PARITY. The next frame's first symbol may be accepted on the cycle after the last parity is loaded.
- Reset mid-frame: all state clears asynchronously; the partial codeword is discarded and no m_tlast is emitted.
- Arithmetic: all additions are XOR; multiplication uses gf_pkg::gf_mult only. No width growth.

Decomposition:
- gf_pkg gains:
  - GEN_POLY: array [PAR_LEN-1:0] of SYMB_WIDTH constants (monic term implicit), generated alongside the existing field tables.
  - typedef for the encoder state enum {MSG, PARITY}.
- One sub-module, rs_enc_lfsr_core: the rem register bank with load/shift controls and fb input. It is combinational multiply plus registers, and keeps the FSM/handshake in the top level clean.

Test Plan:
- All-zero message, L=K_LEN, m_tready=1 -> K_LEN zero symbols, then PAR_LEN zeros; m_tlast on beat K_LEN+PAR_LEN; len_err_o stays 0.
- Single symbol 0x01 with s_tlast -> output beats are 0x01, then GEN_POLY[PAR_LEN-1], ..., GEN_POLY[0]; m_tlast on the last beat.
- Random 239-symbol message, with m_tready toggled randomly (30% low) -> output matches the golden model. Check syndromes: the existing poly-eval path evaluates the codeword at alpha^1..alpha^PAR_LEN and all results are 0. m_tdata is stable while stalled.
- Back-to-back frames of length 5 and 7, s_tvalid held high -> s_tready=0 for exactly the PAR_LEN parity cycles between frames. Total beats are 5+PAR_LEN+7+PAR_LEN with no gaps.
- K_LEN symbols sent without s_tlast -> len_err_o pulses once on the K_LEN-th accept. Parity follows; the next frame encodes correctly.
- aresetn pulled low after 10 message symbols, then released and a fresh 3-symbol frame sent -> m_tvalid drops immediately. The new frame's parity equals a clean encode of those 3 symbols.
